// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the memory arbiter slice: default geometry of the
// RAM port, the default WAIT-state abort limit, the arbiter FSM encoding and
// the requester index convention used on the two-bit request/grant vectors.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int AW_DEF      = 8;   // RAM address width
    localparam int DW_DEF      = 16;  // RAM data / instruction width
    localparam int TIMEOUT_DEF = 15;  // WAIT cycles before abort, 1..255
    localparam int CNT_W       = 8;   // wide enough for any legal TIMEOUT

    // Bit positions inside the req/gnt vectors of the round-robin arbiter.
    localparam int IDX_FETCH = 0;
    localparam int IDX_DATA  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles every bus signal around the arbiter: the read-only fetch port,
// the read/write data port, the shared RAM command/completion port and the
// err/busy status lines.
//   master : arbiter view (drives acks, read data, RAM command, err, busy)
//   slave  : environment view (drives requests, RAM completion)
// ---------------------------------------------------------------------------
interface mem_arbiter_if
    import cpu_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    // Fetch port (read-only)
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_ack;
    logic [DW-1:0] f_rdata;

    // Data port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    // Status
    logic          err;
    logic          busy;

    // RAM side
    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_done;
    logic [DW-1:0] ram_rdata;

    modport master (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
        input  ram_done, ram_rdata,
        output f_ack, f_rdata, d_ack, d_rdata, err, busy,
        output ram_req, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
        output ram_done, ram_rdata,
        input  f_ack, f_rdata, d_ack, d_rdata, err, busy,
        input  ram_req, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin selector. A lone requester is granted directly; on a
// tie the requester that did not win last time is granted. The last-granted
// flag only moves when the owner pulses update with a non-empty grant.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (last-granted = data,
//              so fetch wins the first tie)
//   req[1:0] : bit 0 = fetch, bit 1 = data
//   update   : commit the current grant as "last granted"
//   gnt[1:0] : one-hot grant (combinational), zero when nothing requested
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_data;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_data ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_data <= 1'b1;
        end else if (update && (gnt != 2'b00)) begin
            last_data <= gnt[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-outstanding RAM port between an instruction-fetch port
// (read-only) and a data port (read/write). A four-state FSM picks a winner
// in IDLE, pulses the RAM command in ISSUE, waits for ram_done (or aborts
// after TIMEOUT WAIT cycles) and pulses the winner's ack in RESP.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset; abandons any transaction
//   bus  : mem_arbiter_if.master -- fetch/data ports, RAM port, err, busy
// Parameters: AW address width, DW data width, TIMEOUT (1..255) WAIT limit.
// ---------------------------------------------------------------------------
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       gnt;
    logic             grant_now;
    logic             win_data;      // 1 = data port owns the transaction
    logic [AW-1:0]    addr_q;
    logic             we_q;
    logic [DW-1:0]    wdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timed_out;
    logic             err_q;
    logic [DW-1:0]    f_rdata_q;
    logic [DW-1:0]    d_rdata_q;

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({bus.d_req, bus.f_req}),
        .update (grant_now),
        .gnt    (gnt)
    );

    // A grant is only taken while idle; this also advances the RR pointer.
    assign grant_now = (state_q == IDLE) && (gnt != 2'b00);

    // The WAIT cycle that would be number TIMEOUT without ram_done aborts,
    // so at most TIMEOUT WAIT cycles are spent on one transaction.
    assign timed_out = (cnt_q + CNT_W'(1)) == TO_LIM;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_now) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.ram_done || timed_out) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            win_data  <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;

            if (grant_now) begin
                win_data <= gnt[IDX_DATA];
            end

            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if ((state_q == WAIT) && !bus.ram_done) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // Read data is written into the winner's register on the way
            // into RESP, so it is valid during the ack and held afterwards.
            if (state_q == WAIT) begin
                if (bus.ram_done) begin
                    err_q <= 1'b0;
                    if (win_data) d_rdata_q <= bus.ram_rdata;
                    else          f_rdata_q <= bus.ram_rdata;
                end else if (timed_out) begin
                    err_q <= 1'b1;
                    if (win_data) d_rdata_q <= '0;
                    else          f_rdata_q <= '0;
                end
            end
        end
    end

    // Command latch: captured with the grant; the fetch port cannot write.
    always_ff @(posedge clk) begin
        if (grant_now) begin
            addr_q  <= gnt[IDX_DATA] ? bus.d_addr  : bus.f_addr;
            we_q    <= gnt[IDX_DATA] & bus.d_we;
            wdata_q <= gnt[IDX_DATA] ? bus.d_wdata : '0;
        end
    end

    // RAM command is presented only in ISSUE, so outputs read zero otherwise
    // (including straight out of reset) without resetting the latch.
    assign bus.ram_req   = (state_q == ISSUE);
    assign bus.ram_we    = (state_q == ISSUE) && we_q;
    assign bus.ram_addr  = (state_q == ISSUE) ? addr_q  : '0;
    assign bus.ram_wdata = (state_q == ISSUE) ? wdata_q : '0;

    assign bus.f_ack   = (state_q == RESP) && !win_data;
    assign bus.d_ack   = (state_q == RESP) &&  win_data;
    assign bus.err     = (state_q == RESP) &&  err_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.f_rdata = f_rdata_q;
    assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Stimulus pushes the expected RAM command
// and RAM reply into queues consumed by a RAM responder, and the expected ack
// into a scoreboard queue consumed by a monitor that compares on every ack.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.AW(8), .DW(16)) bus ();

    mem_arbiter #(.AW(8), .DW(16), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          port;   // 0 fetch, 1 data
        logic [15:0] rdata;
        bit          err;
        int          lat;    // -1 = latency not checked
        int          t0;
    } ack_t;

    typedef struct {
        logic [7:0]  addr;
        bit          we;
        logic [15:0] wdata;
    } cmd_t;

    typedef struct {
        int          lat;    // cycles after ISSUE until ram_done; 0 = never
        logic [15:0] word;
    } resp_t;

    ack_t  exp_q[$];
    cmd_t  cmd_q[$];
    resp_t resp_q[$];
    int    stray_cnt = 0;    // written by stimulus only

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ack(input bit port, input logic [15:0] rd, input bit er,
                              input int lat, input int t0);
        ack_t a;
        a.port = port; a.rdata = rd; a.err = er; a.lat = lat; a.t0 = t0;
        exp_q.push_back(a);
    endtask

    task automatic expect_ram(input logic [7:0] addr, input bit we, input logic [15:0] wd,
                              input int lat, input logic [15:0] word);
        cmd_t  c;
        resp_t r;
        c.addr = addr; c.we = we; c.wdata = wd;
        r.lat = lat; r.word = word;
        cmd_q.push_back(c);
        resp_q.push_back(r);
    endtask

    // Waits for n acks, dropping both requests in the cycle of the n-th ack,
    // then expects the arbiter idle with an empty scoreboard.
    task automatic run_until(input int n, input string name);
        int seen = 0;
        int left = 300;
        while (seen < n && left > 0) begin
            @(posedge clk); #1;
            left--;
            if (bus.f_ack || bus.d_ack) begin
                seen++;
                if (seen == n) begin
                    bus.f_req = 1'b0;
                    bus.d_req = 1'b0;
                end
            end
        end
        chk({name, "_ack_count"}, 32'(seen), 32'(n));
        @(posedge clk); #1;
        chk({name, "_idle_after"}, 32'(bus.busy), 32'd0);
        chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: scoreboard compare on every ack, plus one-hot ack and the
    // single-cycle ram_req pulse.
    logic prev_ram_req = 1'b0;
    always @(negedge clk) begin
        ack_t e;
        if (!rst) begin
            if (bus.f_ack || bus.d_ack) begin
                chk("ack_onehot", 32'(bus.f_ack && bus.d_ack), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_port", 32'(bus.d_ack), 32'(e.port));
                    chk("ack_rdata", 32'(e.port ? bus.d_rdata : bus.f_rdata), 32'(e.rdata));
                    chk("ack_err", 32'(bus.err), 32'(e.err));
                    if (e.lat >= 0) chk("ack_latency", 32'(cyc - e.t0), 32'(e.lat));
                end
            end
            if (prev_ram_req) chk("ram_req_pulse", 32'(bus.ram_req), 32'd0);
            prev_ram_req = bus.ram_req;
        end else begin
            prev_ram_req = 1'b0;
        end
    end

    // RAM responder: checks each command and answers after the queued delay;
    // also produces stray ram_done pulses on request from the stimulus.
    initial begin
        cmd_t  c;
        resp_t r;
        int    stray_seen = 0;
        bus.ram_done  = 1'b0;
        bus.ram_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (bus.ram_req && !rst) begin
                if (cmd_q.size() == 0 || resp_q.size() == 0) begin
                    chk("unexpected_ram_req", 32'd1, 32'd0);
                end else begin
                    c = cmd_q.pop_front();
                    r = resp_q.pop_front();
                    chk("ram_addr", 32'(bus.ram_addr), 32'(c.addr));
                    chk("ram_we", 32'(bus.ram_we), 32'(c.we));
                    if (c.we) chk("ram_wdata", 32'(bus.ram_wdata), 32'(c.wdata));
                    if (r.lat > 0) begin
                        repeat (r.lat) @(posedge clk);
                        #1;
                        bus.ram_rdata = r.word;
                        bus.ram_done  = 1'b1;
                        @(posedge clk); #1;
                        bus.ram_done  = 1'b0;
                    end
                end
            end else if (stray_cnt != stray_seen) begin
                stray_seen = stray_cnt;
                @(posedge clk); #1;
                bus.ram_rdata = 16'hDEAD;
                bus.ram_done  = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                bus.ram_done  = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bus.f_req = 1'b0; bus.f_addr = 8'h00;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 8'h00; bus.d_wdata = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_f_ack",     32'(bus.f_ack),     32'd0);
        chk("rst_d_ack",     32'(bus.d_ack),     32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_f_rdata",   32'(bus.f_rdata),   32'd0);
        chk("rst_d_rdata",   32'(bus.d_rdata),   32'd0);
        chk("rst_ram_req",   32'(bus.ram_req),   32'd0);
        chk("rst_ram_we",    32'(bus.ram_we),    32'd0);
        chk("rst_ram_addr",  32'(bus.ram_addr),  32'd0);
        chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Tie after reset: fetch, data, fetch
        t0 = cyc;
        bus.f_req = 1'b1; bus.f_addr = 8'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h30;
        expect_ram(8'h20, 1'b0, 16'h0000, 1, 16'h1111);
        expect_ram(8'h30, 1'b0, 16'h0000, 1, 16'h2222);
        expect_ram(8'h20, 1'b0, 16'h0000, 1, 16'h3333);
        expect_ack(1'b0, 16'h1111, 1'b0, 3,  t0);
        expect_ack(1'b1, 16'h2222, 1'b0, 7,  t0);
        expect_ack(1'b0, 16'h3333, 1'b0, 11, t0);
        run_until(3, "tie");

        // Single fetch, minimum latency
        t0 = cyc;
        bus.f_req = 1'b1; bus.f_addr = 8'h10;
        expect_ram(8'h10, 1'b0, 16'h0000, 1, 16'hA5A5);
        expect_ack(1'b0, 16'hA5A5, 1'b0, 3, t0);
        run_until(1, "fetch");

        // Data write
        t0 = cyc;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h3F; bus.d_wdata = 16'h1234;
        expect_ram(8'h3F, 1'b1, 16'h1234, 1, 16'h0000);
        expect_ack(1'b1, 16'h0000, 1'b0, 3, t0);
        run_until(1, "write");
        chk("f_rdata_hold", 32'(bus.f_rdata), 32'hA5A5);

        // Timeout: no ram_done, 15 WAIT cycles then err
        t0 = cyc;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h44;
        expect_ram(8'h44, 1'b0, 16'h0000, 0, 16'h0000);
        expect_ack(1'b1, 16'h0000, 1'b1, 17, t0);
        run_until(1, "timeout");

        // Fetch request dropped after grant still completes
        t0 = cyc;
        bus.f_req = 1'b1; bus.f_addr = 8'h55;
        expect_ram(8'h55, 1'b0, 16'h0000, 2, 16'h0F0F);
        expect_ack(1'b0, 16'h0F0F, 1'b0, 4, t0);
        @(posedge clk); #1;
        bus.f_req = 1'b0;
        run_until(1, "drop");

        // ram_done while idle is ignored
        stray_cnt++;
        repeat (5) @(posedge clk);
        #1;
        chk("stray_busy",    32'(bus.busy),    32'd0);
        chk("stray_f_rdata", 32'(bus.f_rdata), 32'h0F0F);
        chk("stray_d_rdata", 32'(bus.d_rdata), 32'h0000);

        // Reset during WAIT, then a late ram_done
        bus.f_req = 1'b1; bus.f_addr = 8'h66;
        expect_ram(8'h66, 1'b0, 16'h0000, 0, 16'h0000);
        @(posedge clk); #1;
        bus.f_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("wait_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_wait_busy",    32'(bus.busy),    32'd0);
        chk("rst_wait_f_rdata", 32'(bus.f_rdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        stray_cnt++;
        repeat (5) @(posedge clk);
        #1;
        chk("late_done_busy",    32'(bus.busy),    32'd0);
        chk("late_done_f_rdata", 32'(bus.f_rdata), 32'd0);

        // Normal fetch after reset
        t0 = cyc;
        bus.f_req = 1'b1; bus.f_addr = 8'h10;
        expect_ram(8'h10, 1'b0, 16'h0000, 1, 16'h7777);
        expect_ack(1'b0, 16'h7777, 1'b0, 3, t0);
        run_until(1, "post_rst");

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
